// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports (wr1 wins on a collision),
// and a clear sequencer that zeroes the array after reset or on clr_req, with busy high while it runs.
// Reads take zero cycles and writes one; there is no backpressure, and writes are dropped while busy.
// Optional REGFILE_BYPASS_EN forwards write data to matching reads in the same cycle.
module regfile_mp #(
    parameter int XLEN           = 32,
    parameter int NREGS          = 32,
    parameter int NRD            = 2,
    parameter int ZERO_HARDWIRED = 1,
    localparam int AW            = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                clr_req,
    output logic                busy
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_e;

    localparam logic [AW-1:0] CNT_LAST = AW'(NREGS - 1);
    localparam bit            ZH       = (ZERO_HARDWIRED != 0);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            wr0_ok, wr1_ok;
    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clr_req is deliberately not looked at in CLEAR so a running clear never restarts
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q == S_CLEAR);
        wr1_ok = !busy && wr1_en && !(ZH && (wr1_addr == '0));
        wr0_ok = !busy && wr0_en && !(ZH && (wr0_addr == '0))
                 && !(wr1_ok && (wr1_addr == wr0_addr));
    end

    // Storage has no reset; the sequencer is the only way it gets zeroed.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (wr0_ok) begin
                mem_q[wr0_addr] <= wr0_data;
            end
            if (wr1_ok) begin
                mem_q[wr1_addr] <= wr1_data;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;

        assign ra = rd_addr[g*AW +: AW];

        always_comb begin
            rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
            // wr0_ok is already cleared on an address collision, so wr1 takes priority here
            if (wr0_ok && (wr0_addr == ra)) begin
                rv = wr0_data;
            end
            if (wr1_ok && (wr1_addr == ra)) begin
                rv = wr1_data;
            end
`endif
            if (busy || (ZH && (ra == '0))) begin
                rv = '0;
            end
        end

        assign rd_data[g*XLEN +: XLEN] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: randomized and directed stimulus against an array model.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 3;
    localparam int ZH    = 1;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic                wr0_en = 1'b0;
    logic [AW-1:0]       wr0_addr = '0;
    logic [XLEN-1:0]     wr0_data = '0;
    logic                wr1_en = 1'b0;
    logic [AW-1:0]       wr1_addr = '0;
    logic [XLEN-1:0]     wr1_data = '0;
    logic                clr_req = 1'b0;
    logic                busy;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_HARDWIRED(ZH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                busy;
        logic [NRD*XLEN-1:0] rd;
        logic [NRD*AW-1:0]   ad;
    } exp_t;

    exp_t            sb_q[$];
    logic [XLEN-1:0] mem_m [NREGS];
    int              busy_left = NREGS;
    int              n_cmp = 0;
    int              n_err = 0;
    int              cyc = 0;

    task automatic zero_model();
        for (int a = 0; a < NREGS; a++) mem_m[a] = '0;
    endtask

    function automatic logic [XLEN-1:0] exp_rd(int a);
        if (!rst_n || busy_left > 0) return '0;
        if (ZH != 0 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr1_en && int'(wr1_addr) == a) return wr1_data;
        if (wr0_en && int'(wr0_addr) == a) return wr0_data;
`endif
        return mem_m[a];
    endfunction

    // Push the expected view of the current cycle, then let the edge happen and advance the model.
    task automatic step();
        exp_t e;
        if (!rst_n) begin
            busy_left = NREGS;
            zero_model();
        end
        e.busy = (busy_left > 0);
        e.ad   = rd_addr;
        for (int p = 0; p < NRD; p++) e.rd[p*XLEN +: XLEN] = exp_rd(int'(rd_addr[p*AW +: AW]));
        sb_q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            busy_left = NREGS;
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (wr0_en && !(ZH != 0 && wr0_addr == '0)) mem_m[wr0_addr] = wr0_data;
            if (wr1_en && !(ZH != 0 && wr1_addr == '0)) mem_m[wr1_addr] = wr1_data;
            if (clr_req) begin
                busy_left = NREGS;
                zero_model();
            end
        end
        #1;
    endtask

    task automatic quiet();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic set_rd(int p, int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic sweep();
        quiet();
        for (int a = 0; a < NREGS; a += NRD) begin
            for (int p = 0; p < NRD; p++) set_rd(p, (a + p) % NREGS);
            step();
        end
    endtask

    task automatic run_rand(int n);
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, NREGS - 1));
            wr0_en   = ($urandom_range(0, 9) < 6);
            wr0_addr = AW'($urandom_range(0, 7));
            wr0_data = $urandom();
            wr1_en   = ($urandom_range(0, 9) < 5);
            wr1_addr = AW'($urandom_range(0, NREGS - 1));
            wr1_data = $urandom();
            if ($urandom_range(0, 5) == 0) wr1_addr = wr0_addr;
            if ($urandom_range(0, 2) == 0) set_rd(0, int'(wr0_addr));
            if ($urandom_range(0, 2) == 0) set_rd(1, int'(wr1_addr));
            clr_req  = ($urandom_range(0, 149) == 0);
            step();
        end
        quiet();
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cyc++;
            n_cmp++;
            if (busy !== e.busy) begin
                n_err++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e.busy);
            end
            for (int p = 0; p < NRD; p++) begin
                n_cmp++;
                if (rd_data[p*XLEN +: XLEN] !== e.rd[p*XLEN +: XLEN]) begin
                    n_err++;
                    $display("FAIL rd%0d cyc=%0d addr=%0d got=%h exp=%h", p, cyc,
                             e.ad[p*AW +: AW], rd_data[p*XLEN +: XLEN], e.rd[p*XLEN +: XLEN]);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset held, then the initial clear; a write attempt to x4 during it must be dropped
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;
        for (int i = 0; i < NREGS + 2; i++) begin
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, NREGS - 1));
            wr0_en = (i == 5); wr0_addr = AW'(4); wr0_data = 32'hCAFE_0004;
            step();
        end
        quiet();
        sweep();

        wr0_en = 1'b1; wr0_addr = AW'(5); wr0_data = 32'hDEAD_BEEF;
        wr1_en = 1'b1; wr1_addr = AW'(7); wr1_data = 32'h1234_5678;
        step();
        quiet(); set_rd(0, 5); set_rd(1, 7); set_rd(2, 5);
        step();

        wr0_en = 1'b1; wr0_addr = AW'(9); wr0_data = 32'h0000_1111;
        wr1_en = 1'b1; wr1_addr = AW'(9); wr1_data = 32'h0000_2222;
        step();
        wr0_en = 1'b1; wr0_addr = AW'(0); wr0_data = 32'h0000_FFFF;
        wr1_en = 1'b0; set_rd(0, 9);
        step();
        quiet(); set_rd(0, 0); set_rd(1, 9); set_rd(2, 0);
        step();

        wr0_en = 1'b1; wr0_addr = AW'(3); wr0_data = 32'h55;
        step();
        wr0_data = 32'hAA; set_rd(0, 3); set_rd(1, 3); set_rd(2, 5);
        step();
        quiet();
        step();

        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wr1_en = 1'b1; wr1_addr = AW'(4); wr1_data = 32'h4444_4444; set_rd(0, 4);
        step();
        quiet();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < NREGS; i++) step();
        sweep();

        run_rand(200);

        clr_req = 1'b1;
        step();
        quiet();
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NREGS + 2; i++) begin
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, NREGS - 1));
            step();
        end
        sweep();

        run_rand(600);
        sweep();

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain left=%0d exp=0", sb_q.size());
        end
        n_cmp++;
        if (cyc < 900) begin
            n_err++;
            $display("FAIL monitor_cycles got=%0d exp>=900", cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timed out");
    end

endmodule
